// File: rtl/lsu_rmw_ctrl_if.sv
// Core-side request/response handshake and word-bank port of the LSU read-modify-write front end.
// The slave modport is the LSU itself; the master modport is the core/bank environment around it.
interface lsu_rmw_ctrl_if #(
  parameter int DMEM_W    = 11,
  parameter int DMEM_ADDR = 9
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [DMEM_W-1:0]    req_addr_i;
  logic [2:0]           req_funct3_i;
  logic [31:0]          req_wdata_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [31:0]          rsp_rdata_o;
  logic                 rsp_err_o;

  logic [DMEM_ADDR-1:0] paddr_o;
  logic                 penable_o;
  logic                 pwrite_o;
  logic [31:0]          pwdata_o;
  logic [2:0]           pfunct_code_o;
  logic [31:0]          prdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_funct3_i, req_wdata_i,
    input  rsp_ready_i, prdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output paddr_o, penable_o, pwrite_o, pwdata_o, pfunct_code_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_funct3_i, req_wdata_i,
    output rsp_ready_i, prdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  paddr_o, penable_o, pwrite_o, pwdata_o, pfunct_code_o
  );
endinterface

// File: rtl/lsu_rmw_ctrl.sv
// LSU front end: byte/half/word loads and stores mapped onto a word-only memory bank,
// with sub-word stores performed as a read-modify-write and loads extended locally.
module lsu_rmw_ctrl #(
  parameter int DMEM_W    = 11,
  parameter int DMEM_ADDR = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  lsu_rmw_ctrl_if.slave bus
);

  localparam logic [2:0] F3_B      = 3'b000;
  localparam logic [2:0] F3_H      = 3'b001;
  localparam logic [2:0] F3_W      = 3'b010;
  localparam logic [2:0] F3_BU     = 3'b100;
  localparam logic [2:0] F3_HU     = 3'b101;
  localparam logic [2:0] FUNCT_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return !off[0];
      F3_W:    return off == 2'b00;
      F3_BU:   return !we;
      F3_HU:   return !we && !off[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'd0, b};
      F3_HU:   return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Only byte and half stores reach the merge; the other lanes keep the word just read.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] m;
    m = word;
    if (f3 == F3_B) m[{off, 3'b000} +: 8] = wdata[7:0];
    else            m[{off[1], 4'b0000} +: 16] = wdata[15:0];
    return m;
  endfunction

  // NOTE: every state and output register below is assigned with <= so all of them sample
  // the same pre-edge values; blocking assignments here would make results depend on order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= IDLE;
      we_q               <= 1'b0;
      off_q              <= 2'b00;
      funct3_q           <= 3'b000;
      wdata_q            <= 32'd0;
      bus.req_ready_o    <= 1'b1;
      bus.rsp_valid_o    <= 1'b0;
      bus.rsp_rdata_o    <= 32'd0;
      bus.rsp_err_o      <= 1'b0;
      bus.paddr_o        <= '0;
      bus.penable_o      <= 1'b0;
      bus.pwrite_o       <= 1'b0;
      bus.pwdata_o       <= 32'd0;
      bus.pfunct_code_o  <= 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            we_q            <= bus.req_we_i;
            off_q           <= bus.req_addr_i[1:0];
            funct3_q        <= bus.req_funct3_i;
            wdata_q         <= bus.req_wdata_i;
            bus.req_ready_o <= 1'b0;
            if (!req_legal(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i[1:0])) begin
              state_q         <= RESP;
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_err_o   <= 1'b1;
              bus.rsp_rdata_o <= 32'd0;
            end else begin
              // Bank outputs come up together with the state so the access starts cleanly.
              bus.paddr_o       <= bus.req_addr_i[DMEM_W-1:2];
              bus.penable_o     <= 1'b1;
              bus.pfunct_code_o <= FUNCT_WORD;
              if (bus.req_we_i && bus.req_funct3_i == F3_W) begin
                state_q      <= WR;
                bus.pwrite_o <= 1'b1;
                bus.pwdata_o <= bus.req_wdata_i;
              end else begin
                state_q      <= RD;
                bus.pwrite_o <= 1'b0;
              end
            end
          end
        end

        RD: begin
          if (we_q) begin
            state_q      <= WR;
            bus.pwrite_o <= 1'b1;
            bus.pwdata_o <= store_merge(bus.prdata_i, wdata_q, off_q, funct3_q);
          end else begin
            state_q           <= RESP;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_err_o     <= 1'b0;
            bus.rsp_rdata_o   <= load_extract(bus.prdata_i, off_q, funct3_q);
            bus.penable_o     <= 1'b0;
            bus.pfunct_code_o <= 3'd0;
            bus.paddr_o       <= '0;
          end
        end

        WR: begin
          state_q           <= RESP;
          bus.rsp_valid_o   <= 1'b1;
          bus.rsp_err_o     <= 1'b0;
          bus.rsp_rdata_o   <= 32'd0;
          bus.penable_o     <= 1'b0;
          bus.pwrite_o      <= 1'b0;
          bus.pfunct_code_o <= 3'd0;
          bus.paddr_o       <= '0;
          bus.pwdata_o      <= 32'd0;
        end

        RESP: begin
          if (bus.rsp_ready_i) begin
            state_q         <= IDLE;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_rdata_o <= 32'd0;
            bus.req_ready_o <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Self-checking bench for lsu_rmw_ctrl: directed scenarios plus random traffic against a
// byte-array reference model of memory, with a word-wide bank model driving prdata_i.
module tb_lsu_rmw_ctrl;

  logic clk_i = 1'b0;
  logic rst_ni;

  lsu_rmw_ctrl_if #(.DMEM_W(11), .DMEM_ADDR(9)) bus ();

  lsu_rmw_ctrl #(.DMEM_W(11), .DMEM_ADDR(9)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] bank_mem [0:511];
  logic [7:0]  ref_mem  [0:2047];
  int          pen_cnt  = 0;
  int          wr_cnt   = 0;
  logic [8:0]  last_waddr;
  logic [31:0] last_wdata;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd;

  assign bus.prdata_i = bank_mem[bus.paddr_o];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bank model and access monitor; memory contents start identical in bank and reference.
  initial begin
    for (int w = 0; w < 512; w++) begin
      bank_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = bank_mem[w][8*b +: 8];
    end
    forever begin
      @(posedge clk_i);
      if (bus.penable_o) begin
        pen_cnt++;
        check("pfunct_code", {29'd0, bus.pfunct_code_o}, 32'd2);
        if (bus.pwrite_o) begin
          wr_cnt++;
          last_waddr = bus.paddr_o;
          last_wdata = bus.pwdata_o;
          bank_mem[bus.paddr_o] = bus.pwdata_o;
        end
      end
    end
  end

  // Reference: RV32 load/store semantics on a flat byte memory.
  task automatic ref_op(input logic we, input int addr, input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int pen, output int wr);
    int     size;
    bit     uns;
    longint v;
    size = 1 << f3[1:0];
    uns  = f3[2];
    err  = (f3[1:0] == 2'b11) || (uns && (we || size == 4)) || (addr % size != 0);
    rd   = 32'd0;
    if (err) begin
      lat = 1; pen = 0; wr = 0;
    end else if (!we) begin
      v = 0;
      for (int b = 0; b < size; b++) v = v | (longint'(ref_mem[addr+b]) << (8*b));
      if (!uns && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
      rd  = v[31:0];
      lat = 2; pen = 1; wr = 0;
    end else begin
      for (int b = 0; b < size; b++) ref_mem[addr+b] = wd[8*b +: 8];
      lat = (size == 4) ? 2 : 3;
      pen = (size == 4) ? 1 : 2;
      wr  = 1;
    end
  endtask

  // Issue one request from a negedge, wait for the response, hold it for `hold` cycles, consume it.
  task automatic do_req(input logic we, input logic [10:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd,
                        output logic err, output int lat, output int pen, output int wr);
    int guard;
    int pen0;
    int wr0;
    int pen_hold;
    guard = 0;
    while (!bus.req_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    check("req_ready_wait", {31'd0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_addr_i   = addr;
    bus.req_funct3_i = f3;
    bus.req_wdata_i  = wd;
    pen0 = pen_cnt;
    wr0  = wr_cnt;
    @(posedge clk_i);
    #1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'($urandom);
    bus.req_addr_i   = 11'($urandom);
    bus.req_funct3_i = 3'($urandom);
    bus.req_wdata_i  = $urandom;
    lat = 1;
    while (!bus.rsp_valid_o && lat < 10) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check("rsp_timeout", {31'd0, bus.rsp_valid_o}, 32'd1);
    rd       = bus.rsp_rdata_o;
    err      = bus.rsp_err_o;
    pen_hold = pen_cnt;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      check("hold_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
      check("hold_rdata", bus.rsp_rdata_o, rd);
      check("hold_ready", {31'd0, bus.req_ready_o}, 32'd0);
      check("hold_no_bank", pen_cnt, pen_hold);
    end
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rsp_ready_i = 1'b0;
    check("ready_after_rsp", {31'd0, bus.req_ready_o}, 32'd1);
    pen = pen_cnt - pen0;
    wr  = wr_cnt - wr0;
    @(negedge clk_i);
  endtask

  task automatic run(input logic we, input logic [10:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold);
    logic [31:0] e_rd, g_rd;
    logic        e_err, g_err;
    int          e_lat, e_pen, e_wr, g_lat, g_pen, g_wr;
    ref_op(we, int'(addr), f3, wd, e_rd, e_err, e_lat, e_pen, e_wr);
    do_req(we, addr, f3, wd, hold, g_rd, g_err, g_lat, g_pen, g_wr);
    check("rdata", g_rd, e_rd);
    check("err", {31'd0, g_err}, {31'd0, e_err});
    check("latency", g_lat, e_lat);
    check("bank_accesses", g_pen, e_pen);
    check("bank_writes", g_wr, e_wr);
    if (e_wr == 1) check("write_addr", {23'd0, last_waddr}, {23'd0, addr[10:2]});
    last_rd = g_rd;
  endtask

  initial begin
    logic [31:0] saved;
    int          wr_before;
    logic [10:0] a;
    logic [2:0]  f;

    rst_ni           = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_funct3_i = 3'd0;
    bus.req_wdata_i  = 32'd0;
    bus.rsp_ready_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check("rst_penable", {31'd0, bus.penable_o}, 32'd0);
    check("rst_pwrite", {31'd0, bus.pwrite_o}, 32'd0);
    check("rst_paddr", {23'd0, bus.paddr_o}, 32'd0);
    check("rst_pwdata", bus.pwdata_o, 32'd0);
    check("rst_pfunct", {29'd0, bus.pfunct_code_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Reset in the middle of a load's read cycle drops the bank enable at once.
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = 11'h010;
    bus.req_funct3_i = 3'b010;
    @(posedge clk_i);
    #1;
    bus.req_valid_i = 1'b0;
    check("midrd_penable", {31'd0, bus.penable_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrd_rst_penable", {31'd0, bus.penable_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("midrd_rel_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("midrd_rel_valid", {31'd0, bus.rsp_valid_o}, 32'd0);

    // A word store aborted by reset during its write cycle must not reach the bank.
    saved     = bank_mem[16];
    wr_before = wr_cnt;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_addr_i   = 11'h040;
    bus.req_funct3_i = 3'b010;
    bus.req_wdata_i  = ~saved;
    @(posedge clk_i);
    #1;
    bus.req_valid_i = 1'b0;
    check("abort_wr_pwrite", {31'd0, bus.pwrite_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("abort_wr_count", wr_cnt, wr_before);
    check("abort_wr_mem", bank_mem[16], saved);

    // Word store, then a byte store merged into it, then read back.
    run(1'b1, 11'h010, 3'b010, 32'hDEADBEEF, 0);
    check("sw_paddr", {23'd0, last_waddr}, 32'd4);
    check("sw_pwdata", last_wdata, 32'hDEADBEEF);
    run(1'b1, 11'h010, 3'b010, 32'h11223344, 1);
    run(1'b1, 11'h012, 3'b000, 32'h000000AA, 0);
    check("sb_pwdata", last_wdata, 32'h11AA3344);
    run(1'b0, 11'h010, 3'b010, 32'd0, 0);
    check("lw_after_sb", last_rd, 32'h11AA3344);

    // Sign and zero extension.
    run(1'b1, 11'h020, 3'b010, 32'h8000F0FF, 0);
    run(1'b0, 11'h020, 3'b000, 32'd0, 0);
    check("lb_sext", last_rd, 32'hFFFFFFFF);
    run(1'b0, 11'h021, 3'b100, 32'd0, 0);
    check("lbu_zext", last_rd, 32'h000000F0);
    run(1'b0, 11'h022, 3'b001, 32'd0, 0);
    check("lh_sext", last_rd, 32'hFFFF8000);
    run(1'b0, 11'h022, 3'b101, 32'd0, 0);
    check("lhu_zext", last_rd, 32'h00008000);

    // Errors: misaligned half and word, illegal store funct3.
    run(1'b0, 11'h013, 3'b001, 32'd0, 0);
    check("err_lh_mis", last_rd, 32'd0);
    run(1'b0, 11'h012, 3'b010, 32'd0, 0);
    run(1'b1, 11'h010, 3'b100, 32'h55, 2);

    // Back-pressure on a load response.
    run(1'b0, 11'h020, 3'b010, 32'd0, 5);
    check("bp_lw", last_rd, 32'h8000F0FF);

    // Random traffic over a small window so stores and loads collide often.
    for (int i = 0; i < 300; i++) begin
      a = (i % 8 == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 63));
      f = (i % 4 == 0) ? 3'($urandom_range(0, 7)) : 3'(($urandom_range(0, 1) << 2) | $urandom_range(0, 2));
      run(1'($urandom_range(0, 1)), a, f, $urandom, $urandom_range(0, 2));
    end

    for (int w = 0; w < 512; w++)
      check("final_mem", bank_mem[w],
            {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
